// File: rtl/mem_resp_pipe_if.sv
// Request/response bundle between the CPU data port and the memory responder.
// Latency: n/a (wiring only).
// Backpressure: none; the responder accepts every request presented.
// Ports: enable/wr/addr/data_in/tag_in flow master->slave;
//        data_out/data_valid/tag_out/rd_pending flow slave->master.
interface mem_resp_pipe_if #(
  parameter int TAG_W = 2
);
  logic             enable;
  logic             wr;
  logic [15:0]      addr;
  logic [15:0]      data_in;
  logic [TAG_W-1:0] tag_in;
  logic [15:0]      data_out;
  logic             data_valid;
  logic [TAG_W-1:0] tag_out;
  logic             rd_pending;

  modport master (
    output enable, wr, addr, data_in, tag_in,
    input  data_out, data_valid, tag_out, rd_pending
  );

  modport slave (
    input  enable, wr, addr, data_in, tag_in,
    output data_out, data_valid, tag_out, rd_pending
  );
endinterface

// File: rtl/mem_resp_pipe.sv
// Pipelined 16-bit word memory: posted writes, reads returned with a tag.
// Latency: read data/tag/strobe appear LATENCY cycles after the request cycle.
// Backpressure: none; one request per cycle, pipe advances unconditionally.
// Ports: clk, rst (async active-high), bus (slave side of mem_resp_pipe_if).
module mem_resp_pipe #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_resp_pipe_if.slave   bus
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [15:0]       mem [DEPTH];
  logic [MEM_AW-1:0] word_idx;
  logic              rd_acc;
  logic              wr_acc;

  // Stage 0 here is "stage 1" of the read pipe; stage LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] stg_vld;
  logic [15:0]        stg_dat [LATENCY];
  logic [TAG_W-1:0]   stg_tag [LATENCY];

  // Byte address: bit 0 and bits above the word index alias.
  assign word_idx = bus.addr[MEM_AW:1];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[0], bus.addr[15:MEM_AW+1]};

  // Gate with enable first so wr/addr are don't-care on idle cycles.
  assign rd_acc = bus.enable & ~bus.wr;
  assign wr_acc = bus.enable &  bus.wr;

  // Array is never reset: committed writes survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  // Bubbles carry zero data/tag, so the outputs read 0 whenever data_valid=0
  // without an output mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_dat[i] <= '0;
        stg_tag[i] <= '0;
      end
    end else begin
      stg_vld[0] <= rd_acc;
      stg_dat[0] <= rd_acc ? mem[word_idx] : 16'h0000;
      stg_tag[0] <= rd_acc ? bus.tag_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_dat[i] <= stg_dat[i-1];
        stg_tag[i] <= stg_tag[i-1];
      end
    end
  end

  assign bus.data_valid = stg_vld[LATENCY-1];
  assign bus.data_out   = stg_dat[LATENCY-1];
  assign bus.tag_out    = stg_tag[LATENCY-1];

  // Includes the read being presented now so the flag rises in the request cycle.
  assign bus.rd_pending = (|stg_vld) | (rd_acc & ~rst);

endmodule

// File: doc/mem_resp_pipe.md
Name: mem_resp_pipe

Overview:
- Pipelined data-memory responder: the slave end of the enable/wr/addr/data_in request interface that the CPU drives.
- Reads return data a fixed LATENCY cycles after acceptance, with a data_valid strobe and an echoed tag. Writes are posted and commit in the acceptance cycle.
- Models the multi-cycle main memory behind the instruction/data caches and sits where the single-cycle data memory sits today.
- One request per cycle, fully pipelined, no backpressure.

Parameters:
- MEM_AW, 10, word-address bits; array holds 2^MEM_AW 16-bit words.
- LATENCY, 4, cycles from read acceptance to data_valid; legal range 1..8.
- TAG_W, 2, width of request tag echoed with read data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  request present this cycle.
- wr  input  1  1 = write, 0 = read; ignored when enable=0.
- addr  input  16  byte address; word index = addr[MEM_AW:1]; addr[0] ignored; addr[15:MEM_AW+1] ignored (aliases).
- data_in  input  16  write data.
- tag_in  input  TAG_W  request tag, captured on reads.
- data_out  output  16  read data; valid only while data_valid=1.
- data_valid  output  1  one-cycle strobe per accepted read.
- tag_out  output  TAG_W  tag of the read completing this cycle.
- rd_pending  output  1  1 while any accepted read has not yet completed.

Behaviour:
- Reset (async assert, sync-safe release):
  - All pipeline valid bits, data_valid, rd_pending, data_out and tag_out clear to 0 immediately.
  - Memory array contents are not cleared.
  - Reads in flight at reset are dropped and never produce data_valid.
  - Writes that committed before reset persist.
- Acceptance: every cycle with enable=1 and rst=0 is an accepted request. There is no ready signal.
- Write (enable=1, wr=1): mem[addr[MEM_AW:1]] <= data_in at that clock edge. No response, no strobe, no effect on the read pipeline.
- Read (enable=1, wr=0):
  - Array is sampled at the acceptance edge and returns the value after all writes accepted in earlier cycles.
  - Stage 1 captures {valid=1, data, tag_in}.
  - The entry shifts one stage per cycle through a LATENCY-deep shift register.
  - Response outputs are registered, taken from stage LATENCY.
  - A read accepted at edge N drives data_valid=1, data_out, tag_out in the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- Back-to-back reads: one completes per cycle, in order, and no entry is ever dropped. The pipeline advances unconditionally, so it cannot overflow.
- Idle cycles (enable=0) inject valid=0 bubbles.
- When data_valid=0, data_out and tag_out hold 0.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data. Read and write in the same cycle is impossible (single port).
- rd_pending = OR of all stage valid bits plus the incoming accepted read. It is combinational on the stage bits and is 0 only when the pipe is empty and no read is presented.
- LATENCY=1: a read in cycle N gives data_valid in cycle N+1, with no intermediate stages.
- Address wrap: addr=16'hFFFE with MEM_AW=10 maps to word 1023. addr=16'h0800 maps to word 0.
- X-safety: wr and addr are don't-care when enable=0 and must not disturb the array.

Test Plan:
- Reset, then write 16'hBEEF to 0x0010, then read 0x0010 with tag 2'b01. Required: data_valid exactly 4 cycles after the read cycle, data_out=16'hBEEF, tag_out=2'b01, and data_valid low in every other cycle.
- Write 0x1111/0x2222/0x3333 to 0x0000/0x0002/0x0004, then 3 consecutive reads with tags 0,1,2. Required: 3 consecutive strobes carrying 0x1111/0x2222/0x3333 with tags 0/1/2. rd_pending is 1 from the first read cycle through the last strobe, then 0.
- Write 0x00AA to 0x0006, then read 0x0006 in the very next cycle. Required: the read returns 0x00AA, not the old value.
- Alias/LSB check: write 0x5A5A to addr 0x0801, then read 0x0000. Required: 0x5A5A.
- Issue 2 reads, assert rst for 1 cycle 2 cycles after the first read, then issue no requests. Required: no data_valid for the dropped reads and rd_pending=0 after reset. Earlier-written data is still readable after reset.
- Rebuild with LATENCY=1 and interleave read, idle, read. Required: strobes 1 cycle after each read with a bubble between them.
